exc_ctrl: RTL and testbench

Exception and interrupt arbiter at the MEM/commit boundary of the pipeline. It produces the `en_exp` / `exp_*` / `clean_exl` inputs of the cp0 block and consumes cp0's status outputs. It picks one cause per committing instruction, then runs a flush/redirect sequence that steers fetch to the exception vector or, for ERET, to EPC.

---
 rtl/exc_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_exc_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter at the commit boundary: picks one cause, drives cp0, then flushes and redirects fetch.
// Optional feature: define EXC_INT_PENDING_EN to remember interrupts that arrive during commit bubbles.
module exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] BOOT_VEC     = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc,
  input  logic        cm_bd,
  input  logic [6:0]  cm_exc,
  input  logic        cm_eret,
  input  logic [31:0] cm_daddr,
  input  logic        allow_int,
  input  logic        int_exl,
  input  logic        boot_exp_vec,
  input  logic        special_int_vec,
  input  logic [7:0]  interrupt_mask,
  input  logic [5:0]  hardware_int_o,
  input  logic [1:0]  software_int_o,
  input  logic [19:0] ebase,
  input  logic [31:0] epc,
  output logic        en_exp,
  output logic        exp_bd,
  output logic        exp_badv_we,
  output logic        clean_exl,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic [31:0] exp_bad_vaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  // cm_exc bit positions: {ov, bp, sys, ri, ades, adel_d, adel_i}
  localparam int EX_ADEL_I = 0;
  localparam int EX_ADEL_D = 1;
  localparam int EX_ADES   = 2;
  localparam int EX_RI     = 3;
  localparam int EX_SYS    = 4;
  localparam int EX_BP     = 5;
  localparam int EX_OV     = 6;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        is_idle, commit, int_req, int_eff;
  logic        take, eret_take, go;
  logic        int_win, badv_we;
  logic [4:0]  code_sel;
  logic [31:0] badv_val, vec_base, vector, target;

  assign is_idle = (state_q == S_IDLE);
  // rst gates every decision so the combinational outputs read 0 during reset.
  assign commit  = rst & is_idle & cm_valid;
  assign int_req = allow_int & ~int_exl &
                   (|({hardware_int_o, software_int_o} & interrupt_mask));

`ifdef EXC_INT_PENDING_EN
  logic int_pend_q, int_pend_d;

  assign int_eff = int_req | (int_pend_q & allow_int);

  always_comb begin
    int_pend_d = int_pend_q;
    if (!allow_int)
      int_pend_d = 1'b0;
    else if (take && int_win && adv)
      int_pend_d = 1'b0;
    else if (rst && is_idle && !cm_valid && int_req)
      int_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) int_pend_q <= 1'b0;
    else      int_pend_q <= int_pend_d;
  end
`else
  assign int_eff = int_req;
`endif

  assign take      = commit & (int_eff | (|cm_exc));
  assign eret_take = commit & cm_eret & ~take;
  assign go        = (take | eret_take) & adv;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    int_win  = 1'b0;
    code_sel = 5'd0;
    badv_we  = 1'b0;
    badv_val = 32'h0;
    if (int_eff) begin
      int_win  = 1'b1;
      code_sel = 5'd0;
    end else if (cm_exc[EX_ADEL_I]) begin
      code_sel = 5'd4;
      badv_we  = 1'b1;
      badv_val = cm_pc;
    end else if (cm_exc[EX_RI]) begin
      code_sel = 5'd10;
    end else if (cm_exc[EX_SYS]) begin
      code_sel = 5'd8;
    end else if (cm_exc[EX_BP]) begin
      code_sel = 5'd9;
    end else if (cm_exc[EX_OV]) begin
      code_sel = 5'd12;
    end else if (cm_exc[EX_ADEL_D]) begin
      code_sel = 5'd4;
      badv_we  = 1'b1;
      badv_val = cm_daddr;
    end else if (cm_exc[EX_ADES]) begin
      code_sel = 5'd5;
      badv_we  = 1'b1;
      badv_val = cm_daddr;
    end
  end

  assign vec_base = {ebase, 12'h000};

  always_comb begin
    if (boot_exp_vec)
      vector = BOOT_VEC;
    else if (int_win && special_int_vec)
      vector = vec_base + 32'h200;
    else
      vector = vec_base + 32'h180;
  end

  assign target = take ? vector : epc;

  assign en_exp        = take;
  assign exp_bd        = take & cm_bd;
  assign exp_code      = take ? code_sel : 5'd0;
  assign exp_epc       = take ? (cm_bd ? cm_pc - 32'd4 : cm_pc) : 32'h0;
  assign exp_badv_we   = take & badv_we;
  assign exp_bad_vaddr = (take && badv_we) ? badv_val : 32'h0;
  assign clean_exl     = eret_take;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d          = S_FLUSH;
          cnt_d            = 4'(FLUSH_CYCLES);
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
        end
      end
      default: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign flush          = (state_q == S_FLUSH);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized commits against a priority-table model.
module tb_exc_ctrl;

  localparam int FC = 2;

  logic        clk, rst, adv, cm_valid, cm_bd, cm_eret;
  logic [31:0] cm_pc, cm_daddr, epc;
  logic [6:0]  cm_exc;
  logic        allow_int, int_exl, boot_exp_vec, special_int_vec;
  logic [7:0]  interrupt_mask;
  logic [5:0]  hardware_int_o;
  logic [1:0]  software_int_o;
  logic [19:0] ebase;
  logic        en_exp, exp_bd, exp_badv_we, clean_exl, flush, redirect_valid;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc, exp_bad_vaddr, redirect_pc;

  exc_ctrl #(.FLUSH_CYCLES(FC), .BOOT_VEC(32'hBFC00380)) dut (
    .clk(clk), .rst(rst), .adv(adv), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_bd(cm_bd),
    .cm_exc(cm_exc), .cm_eret(cm_eret), .cm_daddr(cm_daddr), .allow_int(allow_int),
    .int_exl(int_exl), .boot_exp_vec(boot_exp_vec), .special_int_vec(special_int_vec),
    .interrupt_mask(interrupt_mask), .hardware_int_o(hardware_int_o),
    .software_int_o(software_int_o), .ebase(ebase), .epc(epc), .en_exp(en_exp),
    .exp_bd(exp_bd), .exp_badv_we(exp_badv_we), .clean_exl(clean_exl), .exp_code(exp_code),
    .exp_epc(exp_epc), .exp_bad_vaddr(exp_bad_vaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  code;
    logic        bd;
    logic        badv_we;
    logic [31:0] epc_v;
    logic [31:0] badv;
    logic        clean;
    logic        int_win;
    logic [31:0] target;
  } decision_t;

  // Synchronous causes in priority order (after Int), with their codes.
  int unsigned prio_bit  [7] = '{0, 3, 4, 5, 6, 1, 2};
  int unsigned prio_code [7] = '{4, 10, 8, 9, 12, 4, 5};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          busy_left = 0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rpc = 32'h0;
  logic        m_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic live_int();
    return allow_int && ((({hardware_int_o, software_int_o}) & interrupt_mask) != 8'h0);
  endfunction

  task automatic model_comb(output decision_t d);
    logic ireq;
    logic found;
    d = '0;
    ireq = live_int();
`ifdef EXC_INT_PENDING_EN
    ireq = ireq || (m_pend && allow_int);
`endif
    if (rst && cm_valid && busy_left == 0) begin
      if (ireq) begin
        d.en = 1'b1;
        d.code = 5'd0;
        d.int_win = 1'b1;
      end else begin
        found = 1'b0;
        for (int k = 0; k < 7; k++) begin
          if (!found && cm_exc[prio_bit[k]]) begin
            found = 1'b1;
            d.en = 1'b1;
            d.code = 5'(prio_code[k]);
            if (prio_bit[k] == 0) begin
              d.badv_we = 1'b1;
              d.badv = cm_pc;
            end else if (prio_bit[k] == 1 || prio_bit[k] == 2) begin
              d.badv_we = 1'b1;
              d.badv = cm_daddr;
            end
          end
        end
      end
      if (d.en) begin
        d.bd = cm_bd;
        d.epc_v = cm_bd ? cm_pc - 32'd4 : cm_pc;
        if (boot_exp_vec) d.target = 32'hBFC00380;
        else d.target = {ebase, 12'h000} + ((d.int_win && special_int_vec) ? 32'd512 : 32'd384);
      end else if (cm_eret) begin
        d.clean = 1'b1;
        d.target = epc;
      end
    end
  endtask

  task automatic model_step(input decision_t d);
    int busy_before;
    busy_before = busy_left;
`ifdef EXC_INT_PENDING_EN
    if (!allow_int) m_pend = 1'b0;
    else if (d.en && d.int_win && adv) m_pend = 1'b0;
    else if (busy_before == 0 && !cm_valid && live_int()) m_pend = 1'b1;
`endif
    if ((d.en || d.clean) && adv) begin
      busy_left = FC;
      m_rv = 1'b1;
      m_rpc = d.target;
    end else begin
      m_rv = 1'b0;
      if (busy_left > 0) busy_left--;
    end
  endtask

  task automatic model_reset();
    busy_left = 0;
    m_rv = 1'b0;
    m_rpc = 32'h0;
    m_pend = 1'b0;
  endtask

  task automatic check_comb(input decision_t d);
    check("en_exp", 32'(en_exp), 32'(d.en));
    check("exp_code", 32'(exp_code), 32'(d.code));
    check("exp_bd", 32'(exp_bd), 32'(d.bd));
    check("exp_badv_we", 32'(exp_badv_we), 32'(d.badv_we));
    check("exp_epc", exp_epc, d.epc_v);
    check("exp_bad_vaddr", exp_bad_vaddr, d.badv);
    check("clean_exl", 32'(clean_exl), 32'(d.clean));
  endtask

  task automatic check_regs();
    check("flush", 32'(flush), 32'(busy_left > 0));
    check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    check("redirect_pc", redirect_pc, m_rpc);
  endtask

  // One commit cycle: check the decision, clock it in, check the registered result.
  task automatic cycle();
    decision_t d;
    #1;
    model_comb(d);
    check_comb(d);
    @(posedge clk);
    model_step(d);
    #1;
    check_regs();
  endtask

  task automatic clear_inputs();
    adv = 1'b1; cm_valid = 1'b0; cm_pc = 32'h0; cm_bd = 1'b0; cm_exc = 7'h0;
    cm_eret = 1'b0; cm_daddr = 32'h0; allow_int = 1'b0; int_exl = 1'b0;
    boot_exp_vec = 1'b0; special_int_vec = 1'b0; interrupt_mask = 8'h0;
    hardware_int_o = 6'h0; software_int_o = 2'h0; ebase = 20'h80000; epc = 32'h0;
  endtask

  task automatic drain();
    clear_inputs();
    for (int i = 0; i < FC + 1; i++) cycle();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    clear_inputs();
    cm_valid = 1'b1;
    cm_exc = 7'h10;
    #12;
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_en_exp", 32'(en_exp), 32'h0);
    check("rst_exp_code", 32'(exp_code), 32'h0);
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Syscall
    cm_valid = 1'b1; cm_pc = 32'h80001000; cm_exc = 7'h10;
    #1;
    check("sys_en", 32'(en_exp), 32'h1);
    check("sys_code", 32'(exp_code), 32'd8);
    check("sys_epc", exp_epc, 32'h80001000);
    cycle();
    check("sys_rpc", redirect_pc, 32'h80000180);
    check("sys_flush1", 32'(flush), 32'h1);
    clear_inputs();
    cycle();
    check("sys_flush2", 32'(flush), 32'h1);
    cycle();
    check("sys_flush_end", 32'(flush), 32'h0);

    // adel_d in a delay slot
    cm_valid = 1'b1; cm_pc = 32'h80000010; cm_bd = 1'b1; cm_exc = 7'h02; cm_daddr = 32'h3;
    #1;
    check("adeld_code", 32'(exp_code), 32'd4);
    check("adeld_epc", exp_epc, 32'h8000000C);
    check("adeld_badv", exp_bad_vaddr, 32'h3);
    check("adeld_badv_we", 32'(exp_badv_we), 32'h1);
    check("adeld_bd", 32'(exp_bd), 32'h1);
    cycle();
    drain();

    // Interrupt beats ri
    cm_valid = 1'b1; cm_pc = 32'h80000400; cm_exc = 7'h08;
    allow_int = 1'b1; hardware_int_o = 6'h20; interrupt_mask = 8'h80;
    #1;
    check("int_code", 32'(exp_code), 32'd0);
    check("int_en", 32'(en_exp), 32'h1);
    check("int_badv_we", 32'(exp_badv_we), 32'h0);
    cycle();
    drain();

    // ERET alone, then ERET with ov
    cm_valid = 1'b1; cm_eret = 1'b1; epc = 32'h80002000;
    #1;
    check("eret_clean", 32'(clean_exl), 32'h1);
    check("eret_en", 32'(en_exp), 32'h0);
    cycle();
    check("eret_rpc", redirect_pc, 32'h80002000);
    drain();
    cm_valid = 1'b1; cm_eret = 1'b1; cm_exc = 7'h40; epc = 32'h80002000;
    #1;
    check("eret_ov_code", 32'(exp_code), 32'd12);
    check("eret_ov_clean", 32'(clean_exl), 32'h0);
    cycle();
    drain();

    // Boot vector, then an exception during FLUSH is ignored
    cm_valid = 1'b1; boot_exp_vec = 1'b1; cm_exc = 7'h20;
    cycle();
    check("boot_rpc", redirect_pc, 32'hBFC00380);
    cm_exc = 7'h10;
    #1;
    check("flush_ignore_en", 32'(en_exp), 32'h0);
    cycle();
    drain();

    // Reset during the first FLUSH cycle
    cm_valid = 1'b1; cm_exc = 7'h40;
    cycle();
    check("pre_rst_flush", 32'(flush), 32'h1);
    rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_flush", 32'(flush), 32'h0);
    check("mid_rst_rv", 32'(redirect_valid), 32'h0);
    check("mid_rst_en", 32'(en_exp), 32'h0);
    clear_inputs();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_regs();

`ifdef EXC_INT_PENDING_EN
    allow_int = 1'b1; hardware_int_o = 6'h01; interrupt_mask = 8'h04; cm_valid = 1'b0;
    cycle();
    hardware_int_o = 6'h00; cm_valid = 1'b1;
    #1;
    check("pend_int_en", 32'(en_exp), 32'h1);
    check("pend_int_code", 32'(exp_code), 32'd0);
    cycle();
    drain();
`endif

    // Randomized commits
    for (int n = 0; n < 500; n++) begin
      adv = ($urandom_range(3) != 0);
      cm_valid = ($urandom_range(3) != 0);
      cm_pc = $urandom & 32'hFFFFFFFC;
      cm_bd = $urandom_range(1);
      cm_daddr = $urandom;
      cm_exc = 7'h0;
      for (int b = 0; b < 7; b++) cm_exc[b] = ($urandom_range(9) == 0);
      cm_eret = ($urandom_range(4) == 0);
      int_exl = ($urandom_range(3) == 0);
      allow_int = int_exl ? 1'b0 : 1'($urandom_range(1));
      interrupt_mask = 8'($urandom);
      hardware_int_o = ($urandom_range(5) == 0) ? 6'($urandom) : 6'h0;
      software_int_o = ($urandom_range(5) == 0) ? 2'($urandom) : 2'h0;
      ebase = 20'($urandom);
      epc = $urandom;
      boot_exp_vec = ($urandom_range(3) == 0);
      special_int_vec = $urandom_range(1);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
